// File: rtl/writeback_controller.sv
// Writeback arbiter for the scalar and vector register files, each fed by scalar pipe, vector pipe or a 2-entry buffer.
// Optional macro WB_PERF_CNT_EN adds saturating push/drain event counters.

module writeback_path #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         stall_mem,
    input  logic         s_wr_en,
    input  logic [4:0]   s_wr_reg,
    input  logic [W-1:0] s_wr_data,
    input  logic         v_wr_en,
    input  logic [4:0]   v_wr_reg,
    input  logic [W-1:0] v_wr_data,
    input  logic         wb_sel,
    input  logic         buf_cap,
    input  logic         buf_sel,
    output logic         wr_en,
    output logic [4:0]   wr_reg,
    output logic [W-1:0] wr_data,
    output logic [1:0]   buf_cnt,
`ifdef WB_PERF_CNT_EN
    output logic         push_evt,
    output logic         pop_evt,
`endif
    output logic         err_evt
);

    logic [4:0]   fifo_reg_r  [2];
    logic [W-1:0] fifo_data_r [2];
    logic         head_r;
    logic         tail_r;
    logic [1:0]   cnt_r;

    logic         pop_s;
    logic         direct_s;
    logic         scalar_s;
    logic         push_req_s;
    logic         push_s;
    logic         write_s;
    logic [4:0]   sel_reg_s;
    logic [W-1:0] sel_data_s;
    logic [1:0]   cnt_next_s;

    // Source priority: buffer drain, then direct vector result, then scalar result.
    always_comb begin
        pop_s      = wb_sel & buf_sel & (cnt_r != 2'd0);
        direct_s   = ~pop_s & wb_sel & v_wr_en & ~buf_cap;
        scalar_s   = ~wb_sel & s_wr_en & ~stall_mem;
        // A direct vector result that loses to a drain is parked in the buffer.
        push_req_s = v_wr_en & (buf_cap | pop_s);
        push_s     = push_req_s & ((cnt_r != 2'd2) | pop_s);
        write_s    = pop_s | direct_s | scalar_s;
        err_evt    = (push_req_s & (cnt_r == 2'd2) & ~pop_s)
                   | (buf_sel & (cnt_r == 2'd0))
                   | (wb_sel & s_wr_en & ~stall_mem);
        if (pop_s) begin
            sel_reg_s  = fifo_reg_r[head_r];
            sel_data_s = fifo_data_r[head_r];
        end else if (direct_s) begin
            sel_reg_s  = v_wr_reg;
            sel_data_s = v_wr_data;
        end else begin
            sel_reg_s  = s_wr_reg;
            sel_data_s = s_wr_data;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_next_s = cnt_r + 2'd1;
            2'b01:   cnt_next_s = cnt_r - 2'd1;
            default: cnt_next_s = cnt_r;
        endcase
    end

    // Buffer storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_reg_r[0]  <= 5'd0;
            fifo_reg_r[1]  <= 5'd0;
            fifo_data_r[0] <= {W{1'b0}};
            fifo_data_r[1] <= {W{1'b0}};
            head_r         <= 1'b0;
            tail_r         <= 1'b0;
            cnt_r          <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_reg_r[tail_r]  <= v_wr_reg;
                fifo_data_r[tail_r] <= v_wr_data;
                tail_r              <= ~tail_r;
            end else begin
                tail_r <= tail_r;
            end
            if (pop_s) begin
                head_r <= ~head_r;
            end else begin
                head_r <= head_r;
            end
            cnt_r <= cnt_next_s;
        end
    end

    // Registered write port; address and data hold between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_reg  <= 5'd0;
            wr_data <= {W{1'b0}};
        end else begin
            wr_en <= write_s;
            if (write_s) begin
                wr_reg  <= sel_reg_s;
                wr_data <= sel_data_s;
            end else begin
                wr_reg  <= wr_reg;
                wr_data <= wr_data;
            end
        end
    end

    assign buf_cnt = cnt_r;
`ifdef WB_PERF_CNT_EN
    assign push_evt = push_s;
    assign pop_evt  = pop_s;
`endif

endmodule

module writeback_controller #(
    parameter int DATA_W = 32,
    parameter int VEC_W  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_mem,
    input  logic              s_reg_wr_en,
    input  logic              s_vec_wr_en,
    input  logic [4:0]        s_wr_reg,
    input  logic [DATA_W-1:0] s_reg_data,
    input  logic [VEC_W-1:0]  s_vec_data,
    input  logic              v_reg_wr_en,
    input  logic              v_vec_wr_en,
    input  logic [4:0]        v_wr_reg,
    input  logic [DATA_W-1:0] v_reg_data,
    input  logic [VEC_W-1:0]  v_vec_data,
    input  logic              register_wb_sel,
    input  logic              vector_wb_sel,
    input  logic              buffer_register,
    input  logic              buffer_vector,
    input  logic              buffer_register_sel,
    input  logic              buffer_vector_sel,
    output logic              rf_wr_en,
    output logic [4:0]        rf_wr_reg,
    output logic [DATA_W-1:0] rf_wr_data,
    output logic              vrf_wr_en,
    output logic [4:0]        vrf_wr_reg,
    output logic [VEC_W-1:0]  vrf_wr_data,
    output logic [1:0]        reg_buf_cnt,
    output logic [1:0]        vec_buf_cnt,
    output logic              wb_err
`ifdef WB_PERF_CNT_EN
    ,
    output logic [15:0]       perf_buf_events,
    output logic [15:0]       perf_drains
`endif
);

    logic reg_err_s;
    logic vec_err_s;
`ifdef WB_PERF_CNT_EN
    logic reg_push_s;
    logic reg_pop_s;
    logic vec_push_s;
    logic vec_pop_s;
`endif

    writeback_path #(.W(DATA_W)) u_reg_path (
        .clk       (clk),
        .rst       (rst),
        .stall_mem (stall_mem),
        .s_wr_en   (s_reg_wr_en),
        .s_wr_reg  (s_wr_reg),
        .s_wr_data (s_reg_data),
        .v_wr_en   (v_reg_wr_en),
        .v_wr_reg  (v_wr_reg),
        .v_wr_data (v_reg_data),
        .wb_sel    (register_wb_sel),
        .buf_cap   (buffer_register),
        .buf_sel   (buffer_register_sel),
        .wr_en     (rf_wr_en),
        .wr_reg    (rf_wr_reg),
        .wr_data   (rf_wr_data),
        .buf_cnt   (reg_buf_cnt),
`ifdef WB_PERF_CNT_EN
        .push_evt  (reg_push_s),
        .pop_evt   (reg_pop_s),
`endif
        .err_evt   (reg_err_s)
    );

    writeback_path #(.W(VEC_W)) u_vec_path (
        .clk       (clk),
        .rst       (rst),
        .stall_mem (stall_mem),
        .s_wr_en   (s_vec_wr_en),
        .s_wr_reg  (s_wr_reg),
        .s_wr_data (s_vec_data),
        .v_wr_en   (v_vec_wr_en),
        .v_wr_reg  (v_wr_reg),
        .v_wr_data (v_vec_data),
        .wb_sel    (vector_wb_sel),
        .buf_cap   (buffer_vector),
        .buf_sel   (buffer_vector_sel),
        .wr_en     (vrf_wr_en),
        .wr_reg    (vrf_wr_reg),
        .wr_data   (vrf_wr_data),
        .buf_cnt   (vec_buf_cnt),
`ifdef WB_PERF_CNT_EN
        .push_evt  (vec_push_s),
        .pop_evt   (vec_pop_s),
`endif
        .err_evt   (vec_err_s)
    );

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_err <= 1'b0;
        end else begin
            wb_err <= wb_err | reg_err_s | vec_err_s;
        end
    end

`ifdef WB_PERF_CNT_EN
    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic a, input logic b);
        logic [16:0] s;
        s = {1'b0, c} + {16'd0, a} + {16'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Saturating event counters summed over both paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_buf_events <= 16'd0;
            perf_drains     <= 16'd0;
        end else begin
            perf_buf_events <= sat_add(perf_buf_events, reg_push_s, vec_push_s);
            perf_drains     <= sat_add(perf_drains, reg_pop_s, vec_pop_s);
        end
    end
`endif

endmodule

// File: tb/tb_writeback_controller.sv
// Self-checking bench for writeback_controller: queue-based reference model plus directed scenarios.
module tb_writeback_controller;

    localparam int DATA_W = 32;
    localparam int VEC_W  = 128;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              stall_mem, s_reg_wr_en, s_vec_wr_en, v_reg_wr_en, v_vec_wr_en;
    logic [4:0]        s_wr_reg, v_wr_reg;
    logic [DATA_W-1:0] s_reg_data, v_reg_data;
    logic [VEC_W-1:0]  s_vec_data, v_vec_data;
    logic              register_wb_sel, vector_wb_sel, buffer_register, buffer_vector;
    logic              buffer_register_sel, buffer_vector_sel;
    logic              rf_wr_en, vrf_wr_en, wb_err;
    logic [4:0]        rf_wr_reg, vrf_wr_reg;
    logic [DATA_W-1:0] rf_wr_data;
    logic [VEC_W-1:0]  vrf_wr_data;
    logic [1:0]        reg_buf_cnt, vec_buf_cnt;

    always #5 clk = ~clk;

    writeback_controller #(.DATA_W(DATA_W), .VEC_W(VEC_W)) dut (
        .clk(clk), .rst(rst), .stall_mem(stall_mem),
        .s_reg_wr_en(s_reg_wr_en), .s_vec_wr_en(s_vec_wr_en), .s_wr_reg(s_wr_reg),
        .s_reg_data(s_reg_data), .s_vec_data(s_vec_data),
        .v_reg_wr_en(v_reg_wr_en), .v_vec_wr_en(v_vec_wr_en), .v_wr_reg(v_wr_reg),
        .v_reg_data(v_reg_data), .v_vec_data(v_vec_data),
        .register_wb_sel(register_wb_sel), .vector_wb_sel(vector_wb_sel),
        .buffer_register(buffer_register), .buffer_vector(buffer_vector),
        .buffer_register_sel(buffer_register_sel), .buffer_vector_sel(buffer_vector_sel),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_data(rf_wr_data),
        .vrf_wr_en(vrf_wr_en), .vrf_wr_reg(vrf_wr_reg), .vrf_wr_data(vrf_wr_data),
        .reg_buf_cnt(reg_buf_cnt), .vec_buf_cnt(vec_buf_cnt), .wb_err(wb_err)
    );

    typedef struct { logic [4:0] r; logic [127:0] d; } ent_t;
    ent_t         rq[$];
    ent_t         vq[$];
    logic         exp_en   [2];
    logic [4:0]   exp_reg  [2];
    logic [127:0] exp_data [2];
    int           exp_cnt  [2];
    logic         exp_err;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One writeback path of the reference model, following the rules literally with a queue as the buffer.
    task automatic model_path(input int p, input logic wb, input logic drain, input logic cap,
                              input logic v_en, input logic [4:0] v_reg, input logic [127:0] v_data,
                              input logic s_en, input logic [4:0] s_reg, input logic [127:0] s_data);
        ent_t q[$];
        ent_t e;
        bit   popped = 0;
        bit   wr = 0;
        if (p == 0) q = rq; else q = vq;
        if (drain && q.size() == 0) exp_err = 1'b1;
        if (wb && s_en && !stall_mem) exp_err = 1'b1;
        if (wb && drain && q.size() > 0) begin
            e = q.pop_front(); popped = 1; wr = 1;
        end else if (wb && v_en && !cap) begin
            e.r = v_reg; e.d = v_data; wr = 1;
        end else if (!wb && s_en && !stall_mem) begin
            e.r = s_reg; e.d = s_data; wr = 1;
        end
        if (v_en && (cap || popped)) begin
            if (q.size() < 2) begin
                ent_t n;
                n.r = v_reg; n.d = v_data;
                q.push_back(n);
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_en[p] = wr;
        if (wr) begin
            exp_reg[p]  = e.r;
            exp_data[p] = e.d;
        end
        exp_cnt[p] = q.size();
        if (p == 0) rq = q; else vq = q;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rq.delete(); vq.delete();
            for (int p = 0; p < 2; p++) begin
                exp_en[p] = 1'b0; exp_reg[p] = 5'd0; exp_data[p] = 128'd0; exp_cnt[p] = 0;
            end
            exp_err = 1'b0;
        end else begin
            model_path(0, register_wb_sel, buffer_register_sel, buffer_register, v_reg_wr_en, v_wr_reg,
                       {96'd0, v_reg_data}, s_reg_wr_en, s_wr_reg, {96'd0, s_reg_data});
            model_path(1, vector_wb_sel, buffer_vector_sel, buffer_vector, v_vec_wr_en, v_wr_reg,
                       v_vec_data, s_vec_wr_en, s_wr_reg, s_vec_data);
        end
    end

    always @(negedge clk) begin
        chk("m_rf_en",    {127'd0, rf_wr_en},     {127'd0, exp_en[0]});
        chk("m_rf_reg",   {123'd0, rf_wr_reg},    {123'd0, exp_reg[0]});
        chk("m_rf_data",  {96'd0, rf_wr_data},    exp_data[0]);
        chk("m_vrf_en",   {127'd0, vrf_wr_en},    {127'd0, exp_en[1]});
        chk("m_vrf_reg",  {123'd0, vrf_wr_reg},   {123'd0, exp_reg[1]});
        chk("m_vrf_data", vrf_wr_data,            exp_data[1]);
        chk("m_reg_cnt",  {126'd0, reg_buf_cnt},  128'(exp_cnt[0]));
        chk("m_vec_cnt",  {126'd0, vec_buf_cnt},  128'(exp_cnt[1]));
        chk("m_wb_err",   {127'd0, wb_err},       {127'd0, exp_err});
    end

    task automatic idle();
        stall_mem = 1'b0; s_reg_wr_en = 1'b0; s_vec_wr_en = 1'b0; v_reg_wr_en = 1'b0; v_vec_wr_en = 1'b0;
        s_wr_reg = 5'd0; v_wr_reg = 5'd0; s_reg_data = 32'd0; v_reg_data = 32'd0;
        s_vec_data = 128'd0; v_vec_data = 128'd0;
        register_wb_sel = 1'b0; vector_wb_sel = 1'b0; buffer_register = 1'b0; buffer_vector = 1'b0;
        buffer_register_sel = 1'b0; buffer_vector_sel = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_reg(input logic [4:0] r, input logic [31:0] d);
        idle(); buffer_register = 1'b1; v_reg_wr_en = 1'b1; v_wr_reg = r; v_reg_data = d;
        cyc();
    endtask

    initial begin
        idle();
        #12 rst = 1'b0;
        chk("reset_en",  {127'd0, rf_wr_en}, 128'd0);
        chk("reset_cnt", {126'd0, reg_buf_cnt}, 128'd0);

        // Scalar-only write
        idle(); s_reg_wr_en = 1'b1; s_wr_reg = 5'd5; s_reg_data = 32'hA5A5_0001;
        cyc();
        chk("scalar_en", {127'd0, rf_wr_en}, 128'd1);
        chk("scalar_reg", {123'd0, rf_wr_reg}, 128'd5);
        chk("scalar_data", {96'd0, rf_wr_data}, 128'hA5A5_0001);
        idle(); cyc();
        chk("pulse_en", {127'd0, rf_wr_en}, 128'd0);
        chk("hold_data", {96'd0, rf_wr_data}, 128'hA5A5_0001);

        // Stalled scalar is not written
        idle(); s_reg_wr_en = 1'b1; s_wr_reg = 5'd6; stall_mem = 1'b1;
        cyc();
        chk("stall_en", {127'd0, rf_wr_en}, 128'd0);

        // Buffer then drain
        push_reg(5'd7, 32'h1234);
        chk("buf_cnt1", {126'd0, reg_buf_cnt}, 128'd1);
        chk("buf_nowr", {127'd0, rf_wr_en}, 128'd0);
        idle(); s_reg_wr_en = 1'b1; s_wr_reg = 5'd7; s_reg_data = 32'h9999;
        cyc();
        chk("buf_scalar", {96'd0, rf_wr_data}, 128'h9999);
        idle(); register_wb_sel = 1'b1; buffer_register_sel = 1'b1;
        cyc();
        chk("drain_en", {127'd0, rf_wr_en}, 128'd1);
        chk("drain_reg", {123'd0, rf_wr_reg}, 128'd7);
        chk("drain_data", {96'd0, rf_wr_data}, 128'h1234);
        chk("drain_cnt0", {126'd0, reg_buf_cnt}, 128'd0);

        // Drain collides with a direct vector result
        push_reg(5'd3, 32'h33);
        idle(); register_wb_sel = 1'b1; buffer_register_sel = 1'b1;
        v_reg_wr_en = 1'b1; v_wr_reg = 5'd4; v_reg_data = 32'h44;
        cyc();
        chk("coll_reg", {123'd0, rf_wr_reg}, 128'd3);
        chk("coll_data", {96'd0, rf_wr_data}, 128'h33);
        chk("coll_cnt", {126'd0, reg_buf_cnt}, 128'd1);
        chk("coll_err", {127'd0, wb_err}, 128'd0);
        idle(); register_wb_sel = 1'b1; buffer_register_sel = 1'b1;
        cyc();
        chk("coll_next", {123'd0, rf_wr_reg}, 128'd4);

        // Vector path: direct, stall, push+pop with capture
        idle(); vector_wb_sel = 1'b1; v_vec_wr_en = 1'b1; v_wr_reg = 5'd9;
        v_vec_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        cyc();
        chk("vdir_reg", {123'd0, vrf_wr_reg}, 128'd9);
        chk("vdir_data", vrf_wr_data, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
        idle(); s_vec_wr_en = 1'b1; stall_mem = 1'b1;
        cyc();
        chk("vstall_en", {127'd0, vrf_wr_en}, 128'd0);
        idle(); buffer_vector = 1'b1; v_vec_wr_en = 1'b1; v_wr_reg = 5'd1; v_vec_data = 128'hAAAA;
        cyc();
        idle(); vector_wb_sel = 1'b1; buffer_vector_sel = 1'b1;
        buffer_vector = 1'b1; v_vec_wr_en = 1'b1; v_wr_reg = 5'd2; v_vec_data = 128'hBBBB;
        cyc();
        chk("vpp_data", vrf_wr_data, 128'hAAAA);
        chk("vpp_cnt", {126'd0, vec_buf_cnt}, 128'd1);
        idle(); vector_wb_sel = 1'b1; buffer_vector_sel = 1'b1;
        cyc();
        chk("vpp_next", vrf_wr_data, 128'hBBBB);
        chk("no_err_yet", {127'd0, wb_err}, 128'd0);

        // Overflow
        push_reg(5'd10, 32'hA);
        push_reg(5'd11, 32'hB);
        chk("ovf_err0", {127'd0, wb_err}, 128'd0);
        push_reg(5'd12, 32'hC);
        chk("ovf_cnt", {126'd0, reg_buf_cnt}, 128'd2);
        chk("ovf_err1", {127'd0, wb_err}, 128'd1);
        idle(); register_wb_sel = 1'b1; buffer_register_sel = 1'b1;
        cyc();
        chk("ovf_d1", {96'd0, rf_wr_data}, 128'hA);
        cyc();
        chk("ovf_d2", {96'd0, rf_wr_data}, 128'hB);
        cyc();
        chk("ovf_d3_none", {127'd0, rf_wr_en}, 128'd0);

        // Hazard: vector source wins over scalar
        idle(); register_wb_sel = 1'b1; s_reg_wr_en = 1'b1; s_wr_reg = 5'd21; s_reg_data = 32'h21;
        v_reg_wr_en = 1'b1; v_wr_reg = 5'd20; v_reg_data = 32'h20;
        cyc();
        chk("haz_reg", {123'd0, rf_wr_reg}, 128'd20);

        // Reset mid-operation
        idle(); buffer_register = 1'b1; v_reg_wr_en = 1'b1; buffer_vector = 1'b1; v_vec_wr_en = 1'b1;
        v_wr_reg = 5'd15; v_reg_data = 32'h15; v_vec_data = 128'h15;
        cyc(); cyc();
        idle();
        chk("pre_rst_rcnt", {126'd0, reg_buf_cnt}, 128'd2);
        chk("pre_rst_vcnt", {126'd0, vec_buf_cnt}, 128'd2);
        #2 rst = 1'b1;
        #1;
        chk("rst_rf", {rf_wr_en, rf_wr_reg, rf_wr_data, vrf_wr_en, vrf_wr_reg}, 128'd0);
        chk("rst_vdata", vrf_wr_data, 128'd0);
        chk("rst_cnt_err", {123'd0, reg_buf_cnt, vec_buf_cnt, wb_err}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        register_wb_sel = 1'b1; buffer_register_sel = 1'b1;
        cyc();
        chk("post_rst_en", {127'd0, rf_wr_en}, 128'd0);
        chk("post_rst_err", {127'd0, wb_err}, 128'd1);
        chk("post_rst_cnt", {126'd0, reg_buf_cnt}, 128'd0);

        idle(); cyc(); cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
